// File: rtl/multibyte_add_seq_pkg.sv
// Shared definitions for the byte-serial wide adder: state encoding and default width.
package multibyte_add_seq_pkg;

  localparam int NBYTES_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Existing 8-bit ripple adder cell with carry in and carry out.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// NBYTES-wide add/subtract computed one byte per clock through a single 8-bit adder,
// LSB first, with valid/ready handshakes on both the operand and result sides.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int IDXW = idx_width(NBYTES);

  state_t            state;
  logic [W-1:0]      a_sh;
  logic [W-1:0]      b_sh;
  logic [W-1:0]      sum_sh;
  logic [W-1:0]      sum_next;
  logic              carry_q;
  logic              ovf_q;
  logic [IDXW-1:0]   idx;
  logic [7:0]        add_s;
  logic              add_c;
  logic              last;

  // Signed overflow: operands agree in sign but the result's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  adder_8bit u_add (
    .a    (a_sh[7:0]),
    .b    (b_sh[7:0]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );

  generate
    if (NBYTES == 1) begin : g_one
      assign sum_next = add_s;
    end else begin : g_many
      assign sum_next = {add_s, sum_sh[W-1:8]};
    end
  endgenerate

  assign last      = (idx == IDXW'(NBYTES - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_sh  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            // Subtraction is A + ~B + 1: the +1 enters as the first byte's carry-in.
            b_sh    <= sub ? ~op_b : op_b;
            carry_q <= sub;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 8;
          b_sh    <= b_sh >> 8;
          sum_sh  <= sum_next;
          carry_q <= add_c;
          idx     <= idx + 1'b1;
          if (last) begin
            ovf_q <= signed_ovf(a_sh[7], b_sh[7], add_s[7]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: fixed vectors, backpressure/reset sequences and random ops vs a model.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] rs, output logic rc, output logic ro);
    logic [32:0] u;
    longint      sr;
    if (!s) begin
      u  = {1'b0, a} + {1'b0, b};
      rc = u[32];
      sr = longint'($signed(a)) + longint'($signed(b));
    end else begin
      u  = {1'b0, a} - {1'b0, b};
      rc = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end
    rs = u[31:0];
    ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input bit scramble,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output int lat);
    @(negedge clk);
    chk({nm, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (scramble) begin
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
    end
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1 || lat >= 40) break;
      if (scramble) begin
        chk({nm, ".in_ready_run"}, 64'(in_ready), 64'd0);
        in_valid = 1'($urandom); op_a = $urandom;
      end
    end
    if (out_valid !== 1'b1) begin
      chk({nm, ".timeout"}, 64'(out_valid), 64'd1);
      rs = 'x; rc = 1'bx; ro = 1'bx;
      return;
    end
    rs = sum; rc = cout; ro = overflow;
    for (int i = 0; i < hold; i++) begin
      if (scramble) begin
        in_valid = 1'($urandom); op_a = $urandom;
      end
      @(negedge clk);
      chk({nm, ".hold_sum"},  64'(sum),       64'(rs));
      chk({nm, ".hold_cout"}, 64'(cout),      64'(rc));
      chk({nm, ".hold_ovf"},  64'(overflow),  64'(ro));
      chk({nm, ".hold_ov"},   64'(out_valid), 64'd1);
      chk({nm, ".hold_ir"},   64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk({nm, ".post_ov"}, 64'(out_valid), 64'd0);
    chk({nm, ".post_ir"}, 64'(in_ready),  64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rs, ms;
    logic        rc, ro, mc, mo;
    int          lat;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready",  64'(in_ready),  64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.sum",       64'(sum),       64'd0);
    chk("reset.cout",      64'(cout),      64'd0);
    chk("reset.overflow",  64'(overflow),  64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 0, 1'b0, rs, rc, ro, lat);
      chk($sformatf("vec%0d.sum", i),     64'(rs),  64'(vecs[i].es));
      chk($sformatf("vec%0d.cout", i),    64'(rc),  64'(vecs[i].ec));
      chk($sformatf("vec%0d.ovf", i),     64'(ro),  64'(vecs[i].eo));
      chk($sformatf("vec%0d.latency", i), 64'(lat), 64'(NB + 1));
    end

    // Backpressure with garbage on the operand side during RUN and DONE.
    run_op("bp", 32'h0F0F0F0F, 32'hF1F1F1F1, 1'b0, 3, 1'b1, rs, rc, ro, lat);
    model(32'h0F0F0F0F, 32'hF1F1F1F1, 1'b0, ms, mc, mo);
    chk("bp.sum",  64'(rs), 64'(ms));
    chk("bp.cout", 64'(rc), 64'(mc));
    chk("bp.ovf",  64'(ro), 64'(mo));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp.no_extra", 64'(in_ready), 64'd1);
    end

    // Reset while RUN is on byte index 2.
    @(negedge clk);
    op_a = 32'hDEADBEEF; op_b = 32'h01234567; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid.busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.in_ready",  64'(in_ready),  64'd1);
    chk("rstmid.out_valid", 64'(out_valid), 64'd0);
    chk("rstmid.sum",       64'(sum),       64'd0);
    run_op("after_rst", 32'h12345678, 32'h11111111, 1'b0, 0, 1'b0, rs, rc, ro, lat);
    chk("after_rst.sum",  64'(rs), 64'h23456789);
    chk("after_rst.cout", 64'(rc), 64'd0);
    chk("after_rst.ovf",  64'(ro), 64'd0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 10 == 0) b = a;
      if (i % 10 == 1) a = 32'h80000000;
      model(a, b, s, ms, mc, mo);
      run_op("rnd", a, b, s, int'($urandom_range(0, 2)), bit'($urandom), rs, rc, ro, lat);
      chk("rnd.sum",     64'(rs),  64'(ms));
      chk("rnd.cout",    64'(rc),  64'(mc));
      chk("rnd.ovf",     64'(ro),  64'(mo));
      chk("rnd.latency", 64'(lat), 64'(NB + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
